sakebi_ethernet_frame_rx: RTL and testbench
===========================================

SAKEBI_ETHERNET_FRAME_RX -- requirements
Module: sakebi_ethernet_frame_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte-lane width of both streams; only 8 SHALL be supported.
REQ-002 Parameter MAC_ADDR_WIDTH, default DATA_WIDTH*6 (48), MAC address width.
REQ-003 Parameter ETHERTYPE_WIDTH, default DATA_WIDTH*2 (16), EtherType width.
REQ-004 i_axis_ACLK  in  1  sole clock; all logic SHALL use its rising edge.
REQ-005 i_axis_ARESETn  in  1  asynchronous, active-high reset (1 = reset, despite the name suffix).
REQ-006 i_axis_TVALID  in  1  RX stream byte valid.
REQ-007 o_axis_TREADY  out  1  RX stream ready.
REQ-008 i_axis_TDATA  in  DATA_WIDTH  RX stream byte; frame starts at destination MAC, no preamble/SFD/FCS.
REQ-009 o_axis_TVALID  out  1  payload byte valid.
REQ-010 i_axis_TREADY  in  1  downstream ready.
REQ-011 o_axis_TDATA  out  DATA_WIDTH  payload byte.
REQ-012 o_src_mac_addr  out  MAC_ADDR_WIDTH  last received source MAC.
REQ-013 o_dst_mac_addr  out  MAC_ADDR_WIDTH  last received destination MAC.
REQ-014 o_ethertype  out  ETHERTYPE_WIDTH  last received EtherType.
REQ-015 i_specify_mac_en  in  1  enable destination-MAC filter.
REQ-016 i_mac_addr  in  MAC_ADDR_WIDTH  own MAC for filter.
REQ-017 i_specify_ethertype_en  in  1  enable EtherType filter.
REQ-018 i_ethertype  in  ETHERTYPE_WIDTH  accepted EtherType.

Function
REQ-019 A byte SHALL be accepted only in cycles where i_axis_TVALID and o_axis_TREADY are both 1.
REQ-020 FSM states: DST (6 bytes), SRC (6 bytes), TYPE (2 bytes), PASS, DROP; byte counter 0..5 resets on each state change.
REQ-021 Header fields SHALL be assembled first-byte-most-significant (bytes de ad be ef ca fe -> 48'hdeadbeefcafe; 00 08 -> 16'h0008).
REQ-022 o_dst_mac_addr, o_src_mac_addr, o_ethertype SHALL each update in the cycle after the last byte of that field is accepted, and hold until the same field of the next frame completes.
REQ-023 In DST/SRC/TYPE, o_axis_TREADY SHALL be 1 and a TVALID-low cycle SHALL stall without state change.
REQ-024 On the last TYPE byte the FSM SHALL enter PASS if (!i_specify_mac_en || dst==i_mac_addr || dst==48'hffffffffffff) && (!i_specify_ethertype_en || type==i_ethertype), else DROP; comparison uses the just-assembled values, including the final byte.
REQ-025 In PASS, o_axis_TREADY SHALL equal (!o_axis_TVALID || i_axis_TREADY); each accepted byte SHALL appear on o_axis_TDATA with o_axis_TVALID=1 one cycle later (1-cycle latency, registered).
REQ-026 o_axis_TVALID/o_axis_TDATA SHALL hold stable while o_axis_TVALID=1 and i_axis_TREADY=0, and drop when TREADY=1 with no new byte accepted.
REQ-027 In DROP, o_axis_TREADY SHALL be 1 and payload bytes SHALL be consumed without assertion of o_axis_TVALID.
REQ-028 In PASS or DROP, any cycle with i_axis_TVALID=0 SHALL end the frame and return the FSM to DST; a pending output byte SHALL still be delivered.
REQ-029 Filter inputs SHALL be sampled only at the REQ-024 decision; changes mid-payload have no effect.

Reset
REQ-030 While i_axis_ARESETn=1 (asynchronously): FSM=DST, counter=0, o_axis_TVALID=0, o_axis_TDATA=0, o_src_mac_addr=0, o_dst_mac_addr=0, o_ethertype=0, o_axis_TREADY=0.
REQ-031 After reset release o_axis_TREADY SHALL be 1 from the first clock edge; reset mid-frame SHALL discard the frame and any pending output byte.

Structure
REQ-032 A shared package SHALL hold DATA_WIDTH/MAC_ADDR_WIDTH/ETHERTYPE_WIDTH defaults, the FSM state encoding and the broadcast-MAC constant.
REQ-033 One sub-module, sakebi_axis_out_reg (1-entry output register with valid/ready), is natural; header parse and filter stay in the top.

Verification
REQ-034 Reset high then low, idle TVALID=0 -> all outputs 0, o_axis_TREADY=1, no output beats.
REQ-035 Filters off, bytes de ad be ef ca fe 01..06 00 08 55 one per cycle, i_axis_TREADY=1 -> dst=48'hdeadbeefcafe, src=48'h010203040506, ethertype=16'h0008, one output beat 8'h55 one cycle after acceptance.
REQ-036 MAC filter on, i_mac_addr=48'h112233445566, same frame -> headers still update, payload consumed, o_axis_TVALID never 1; repeat with dst ff..ff -> 8'h55 forwarded.
REQ-037 EtherType filter on, i_ethertype=16'h0800, type 00 08 -> dropped; type 08 00 -> forwarded.
REQ-038 Payload 55 66 77 with i_axis_TREADY=0 two cycles -> o_axis_TDATA holds 55, o_axis_TREADY=0, bytes delivered in order without loss.
REQ-039 TVALID low one cycle in SRC -> stall, header correct; TVALID low in payload then new frame -> second frame parsed from DST; reset asserted mid-header -> outputs return to 0.

Source files
------------

// File: rtl/sakebi_ethernet_frame_rx_pkg.sv
// Shared widths, FSM encoding and constants for the Ethernet frame receiver.
package sakebi_ethernet_frame_rx_pkg;

  localparam int DATA_WIDTH_DEF      = 8;
  localparam int MAC_ADDR_WIDTH_DEF  = DATA_WIDTH_DEF * 6;
  localparam int ETHERTYPE_WIDTH_DEF = DATA_WIDTH_DEF * 2;

  localparam logic [MAC_ADDR_WIDTH_DEF-1:0] BROADCAST_MAC = 48'hffff_ffff_ffff;

  // Byte-counter value on the final byte of a MAC field / EtherType field.
  localparam logic [2:0] MAC_LAST_IDX  = 3'd5;
  localparam logic [2:0] TYPE_LAST_IDX = 3'd1;

  typedef enum logic [2:0] {
    ST_DST,
    ST_SRC,
    ST_TYPE,
    ST_PASS,
    ST_DROP
  } rx_state_e;

endpackage

// File: rtl/sakebi_axis_out_reg.sv
// One-entry registered stream stage: 1-cycle latency; accepts a new beat
// whenever empty or the held beat leaves this cycle, holds data under backpressure.
module sakebi_axis_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  assign in_rdy  = !vld_q || out_rdy;
  assign out_vld = vld_q;
  assign out_dat = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_vld && in_rdy) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end else if (out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/sakebi_ethernet_frame_rx.sv
// Ethernet header parser with dst-MAC/EtherType filter; payload forwarded with
// 1-cycle latency, stalls only on full output register, headers never stall.
module sakebi_ethernet_frame_rx
  import sakebi_ethernet_frame_rx_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int MAC_ADDR_WIDTH  = DATA_WIDTH * 6,
  parameter int ETHERTYPE_WIDTH = DATA_WIDTH * 2
) (
  input  logic                       i_axis_ACLK,
  input  logic                       i_axis_ARESETn,
  input  logic                       i_axis_TVALID,
  output logic                       o_axis_TREADY,
  input  logic [DATA_WIDTH-1:0]      i_axis_TDATA,
  output logic                       o_axis_TVALID,
  input  logic                       i_axis_TREADY,
  output logic [DATA_WIDTH-1:0]      o_axis_TDATA,
  output logic [MAC_ADDR_WIDTH-1:0]  o_src_mac_addr,
  output logic [MAC_ADDR_WIDTH-1:0]  o_dst_mac_addr,
  output logic [ETHERTYPE_WIDTH-1:0] o_ethertype,
  input  logic                       i_specify_mac_en,
  input  logic [MAC_ADDR_WIDTH-1:0]  i_mac_addr,
  input  logic                       i_specify_ethertype_en,
  input  logic [ETHERTYPE_WIDTH-1:0] i_ethertype
);

  rx_state_e                  state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [MAC_ADDR_WIDTH-1:0]  sh_q, sh_d;
  logic [MAC_ADDR_WIDTH-1:0]  dst_q, dst_d;
  logic [MAC_ADDR_WIDTH-1:0]  src_q, src_d;
  logic [ETHERTYPE_WIDTH-1:0] type_q, type_d;
  logic                       rdy_en_q, rdy_en_d;

  logic accept;
  logic push;
  logic out_in_rdy;
  logic mac_ok;
  logic type_ok;

  // Ready is held low through reset and rises on the first edge afterwards.
  assign o_axis_TREADY  = rdy_en_q && ((state_q != ST_PASS) || out_in_rdy);
  assign accept         = i_axis_TVALID && o_axis_TREADY;
  assign push           = accept && (state_q == ST_PASS);
  assign o_dst_mac_addr = dst_q;
  assign o_src_mac_addr = src_q;
  assign o_ethertype    = type_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    dst_d    = dst_q;
    src_d    = src_q;
    type_d   = type_q;
    rdy_en_d = 1'b1;
    mac_ok   = 1'b0;
    type_ok  = 1'b0;

    case (state_q)
      ST_DST, ST_SRC: begin
        if (accept) begin
          sh_d = {sh_q[MAC_ADDR_WIDTH-DATA_WIDTH-1:0], i_axis_TDATA};
          if (cnt_q == MAC_LAST_IDX) begin
            cnt_d = '0;
            if (state_q == ST_DST) begin
              dst_d   = sh_d;
              state_d = ST_SRC;
            end else begin
              src_d   = sh_d;
              state_d = ST_TYPE;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_TYPE: begin
        if (accept) begin
          sh_d = {sh_q[MAC_ADDR_WIDTH-DATA_WIDTH-1:0], i_axis_TDATA};
          if (cnt_q == TYPE_LAST_IDX) begin
            // Decide on the freshly assembled EtherType, not the registered one.
            type_d  = {sh_q[DATA_WIDTH-1:0], i_axis_TDATA};
            mac_ok  = !i_specify_mac_en || (dst_q == i_mac_addr) || (dst_q == BROADCAST_MAC);
            type_ok = !i_specify_ethertype_en || (type_d == i_ethertype);
            state_d = (mac_ok && type_ok) ? ST_PASS : ST_DROP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_PASS, ST_DROP: begin
        if (!i_axis_TVALID) begin
          state_d = ST_DST;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_DST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_axis_ACLK or posedge i_axis_ARESETn) begin
    if (i_axis_ARESETn) begin
      state_q  <= ST_DST;
      cnt_q    <= '0;
      sh_q     <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      type_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      type_q   <= type_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  sakebi_axis_out_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk     (i_axis_ACLK),
    .rst     (i_axis_ARESETn),
    .in_vld  (push),
    .in_dat  (i_axis_TDATA),
    .in_rdy  (out_in_rdy),
    .out_vld (o_axis_TVALID),
    .out_dat (o_axis_TDATA),
    .out_rdy (i_axis_TREADY)
  );

endmodule

// File: tb/tb_sakebi_ethernet_frame_rx.sv
// Directed bench for sakebi_ethernet_frame_rx with hand-computed expectations.
module tb_sakebi_ethernet_frame_rx;

  logic        clk;
  logic        rst;
  logic        i_tvalid;
  logic        o_tready;
  logic [7:0]  i_tdata;
  logic        o_tvalid;
  logic        i_tready;
  logic [7:0]  o_tdata;
  logic [47:0] o_src;
  logic [47:0] o_dst;
  logic [15:0] o_type;
  logic        mac_en;
  logic [47:0] mac_addr;
  logic        type_en;
  logic [15:0] ethertype;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] beats[$];
  int         n_vld = 0;

  sakebi_ethernet_frame_rx dut (
    .i_axis_ACLK            (clk),
    .i_axis_ARESETn         (rst),
    .i_axis_TVALID          (i_tvalid),
    .o_axis_TREADY          (o_tready),
    .i_axis_TDATA           (i_tdata),
    .o_axis_TVALID          (o_tvalid),
    .i_axis_TREADY          (i_tready),
    .o_axis_TDATA           (o_tdata),
    .o_src_mac_addr         (o_src),
    .o_dst_mac_addr         (o_dst),
    .o_ethertype            (o_type),
    .i_specify_mac_en       (mac_en),
    .i_mac_addr             (mac_addr),
    .i_specify_ethertype_en (type_en),
    .i_ethertype            (ethertype)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output-side monitor: records every delivered beat and every valid cycle.
  always @(posedge clk) begin
    if (!rst && o_tvalid) begin
      n_vld++;
      if (i_tready) beats.push_back(o_tdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_tvalid = 1'b1;
    i_tdata  = b;
    step();
  endtask

  task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    for (int i = 0; i < 6; i++) send_byte(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) send_byte(s[47-8*i -: 8]);
    send_byte(t[15:8]);
    send_byte(t[7:0]);
  endtask

  task automatic idle();
    i_tvalid = 1'b0;
    step();
  endtask

  int base_b;
  int base_v;

  initial begin
    rst       = 1'b1;
    i_tvalid  = 1'b0;
    i_tdata   = 8'h00;
    i_tready  = 1'b1;
    mac_en    = 1'b0;
    mac_addr  = 48'h0;
    type_en   = 1'b0;
    ethertype = 16'h0;

    // Reset and idle
    #1;
    chk("rst_tready", o_tready, 0);
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_tdata", o_tdata, 0);
    chk("rst_dst", o_dst, 0);
    #21 rst = 1'b0;
    step();
    chk("post_rst_tready", o_tready, 1);
    base_v = n_vld;
    step(); step();
    chk("idle_tvalid", o_tvalid, 0);
    chk("idle_src", o_src, 0);
    chk("idle_type", o_type, 0);
    chk("idle_no_vld", n_vld - base_v, 0);

    // Basic frame, filters off; check field update timing
    base_b = beats.size();
    for (int i = 0; i < 5; i++) send_byte(8'hde + 8'(0));
    // Five partial dst bytes above form an incomplete header
    idle();
    idle();
    // The partial header left the FSM mid-dst; realign with a reset
    rst = 1'b1; #1; rst = 1'b0; step();
    chk("realign_dst", o_dst, 0);

    send_byte(8'hde); send_byte(8'had); send_byte(8'hbe);
    send_byte(8'hef); send_byte(8'hca);
    chk("dst_hold_before_last", o_dst, 0);
    send_byte(8'hfe);
    chk("dst_after_last", o_dst, 48'hdeadbeefcafe);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    chk("src", o_src, 48'h010203040506);
    send_byte(8'h00); send_byte(8'h08);
    chk("type", o_type, 16'h0008);
    chk("pre_payload_tvalid", o_tvalid, 0);
    send_byte(8'h55);
    chk("beat_tvalid", o_tvalid, 1);
    chk("beat_tdata", o_tdata, 8'h55);
    idle();
    chk("beat_drop", o_tvalid, 0);
    chk("basic_nbeats", beats.size() - base_b, 1);
    chk("basic_beat", beats[base_b], 8'h55);

    // MAC filter: mismatch drops, broadcast forwards
    mac_en   = 1'b1;
    mac_addr = 48'h112233445566;
    base_v   = n_vld;
    send_hdr(48'hdeadbeefcafe, 48'h0a0b0c0d0e0f, 16'h0008);
    chk("drop_src_upd", o_src, 48'h0a0b0c0d0e0f);
    chk("drop_tready", o_tready, 1);
    send_byte(8'h55);
    send_byte(8'h66);
    idle(); idle();
    chk("mac_drop_no_vld", n_vld - base_v, 0);
    base_b = beats.size();
    send_hdr(48'hffffffffffff, 48'h010203040506, 16'h0008);
    chk("bcast_dst", o_dst, 48'hffffffffffff);
    send_byte(8'h55);
    idle(); idle();
    chk("bcast_nbeats", beats.size() - base_b, 1);
    chk("bcast_beat", beats[base_b], 8'h55);

    // EtherType filter
    mac_en    = 1'b0;
    type_en   = 1'b1;
    ethertype = 16'h0800;
    base_v    = n_vld;
    send_hdr(48'hdeadbeefcafe, 48'h010203040506, 16'h0008);
    send_byte(8'h55);
    idle(); idle();
    chk("type_drop_no_vld", n_vld - base_v, 0);
    base_b = beats.size();
    send_hdr(48'hdeadbeefcafe, 48'h010203040506, 16'h0800);
    chk("type_0800", o_type, 16'h0800);
    send_byte(8'h55);
    idle(); idle();
    chk("type_pass_nbeats", beats.size() - base_b, 1);
    type_en = 1'b0;

    // Downstream backpressure
    base_b = beats.size();
    i_tready = 1'b0;
    send_hdr(48'hdeadbeefcafe, 48'h010203040506, 16'h0008);
    send_byte(8'h55);
    chk("bp_tvalid", o_tvalid, 1);
    chk("bp_tready0", o_tready, 0);
    i_tdata = 8'h66;
    step();
    chk("bp_hold1", o_tdata, 8'h55);
    chk("bp_tready1", o_tready, 0);
    step();
    chk("bp_hold2", o_tdata, 8'h55);
    chk("bp_tvalid2", o_tvalid, 1);
    i_tready = 1'b1;
    #1;
    chk("bp_tready_release", o_tready, 1);
    step();
    chk("bp_next", o_tdata, 8'h66);
    send_byte(8'h77);
    idle(); idle();
    chk("bp_nbeats", beats.size() - base_b, 3);
    chk("bp_b0", beats[base_b], 8'h55);
    chk("bp_b1", beats[base_b+1], 8'h66);
    chk("bp_b2", beats[base_b+2], 8'h77);

    // TVALID gap in SRC stalls without corrupting the header
    for (int i = 0; i < 6; i++) send_byte(8'ha0 + 8'(i));
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle();
    chk("stall_src_hold", o_src, 48'h010203040506);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    chk("stall_src", o_src, 48'h112233445566);
    chk("stall_dst", o_dst, 48'ha0a1a2a3a4a5);
    send_byte(8'h86); send_byte(8'hdd);
    chk("stall_type", o_type, 16'h86dd);

    // Payload ended by TVALID gap; next frame parsed from DST
    base_b = beats.size();
    send_byte(8'haa);
    idle();
    send_hdr(48'h0c0d0e0f1011, 48'h212223242526, 16'h0806);
    chk("f2_dst", o_dst, 48'h0c0d0e0f1011);
    chk("f2_src", o_src, 48'h212223242526);
    chk("f2_type", o_type, 16'h0806);
    send_byte(8'hbb);
    idle();
    chk("f2_nbeats", beats.size() - base_b, 2);
    chk("f2_beat", beats[base_b+1], 8'hbb);

    // Reset mid-header clears outputs and discards the partial frame
    send_byte(8'h99); send_byte(8'h98); send_byte(8'h97);
    rst = 1'b1;
    #1;
    chk("mid_rst_dst", o_dst, 0);
    chk("mid_rst_src", o_src, 0);
    chk("mid_rst_type", o_type, 0);
    chk("mid_rst_tready", o_tready, 0);
    rst = 1'b0;
    i_tvalid = 1'b0;
    step();
    send_hdr(48'h102030405060, 48'h0708090a0b0c, 16'h0008);
    chk("after_rst_dst", o_dst, 48'h102030405060);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
